cache_rd_wr_ctrl: RTL and testbench

Sequencer for the 7-channel line cache.
- Write side: accepts a pixel stream and writes each image row into one cache channel, rotating through the channels as a circular line buffer.
- Read side: on request, sweeps the cache column by column. The channel-select mask enables the oldest kernel_rows complete rows. After each sweep the oldest row is released, giving a stride-1 sliding row window for the PE array.
- Sits between the input DMA/stream and the cache, and drives all cache control ports.

---
 rtl/cache_rd_wr_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_cache_rd_wr_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rd_wr_ctrl.sv
// cache_rd_wr_ctrl
// Read/write sequencer for the 7-channel line cache.
//   Write side: takes a pixel stream and writes each row into one cache channel.
//     The channels are used in rotation as a circular line buffer.
//   Read side: on start_i, sweeps one full row width of addresses.
//     The channel mask selects the oldest kernel_rows complete rows.
//     The oldest row is released after every sweep, so the window slides by one row.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pixel_i/pixel_valid_i           incoming pixel stream
//   pixel_ready_o                   stream ready (no free row slot -> 0)
//   kernel_rows_i, start_i          window height, sweep request
//   flush_i                         synchronous clear of all row state
//   wr_en_o, channel_wr_sel_o,
//   address_wr_o, cache_data_o      cache write port (registered)
//   rd_en_o, channel_rd_sel_o,
//   address_rd_o                    cache read port
//   fetch_valid_o                   cache read data valid (read latency 1)
//   window_base_o                   channel of the top row of the current window
//   rows_filled_o                   complete, unreleased rows
//   done_o                          one-cycle pulse at the end of a sweep
module cache_rd_wr_ctrl #(
  parameter int BIT_WIDTH               = 8,
  parameter int CACHE_CHANNELS          = 7,
  parameter int CACHE_CHANNEL_BIT_WIDTH = 3,
  parameter int CACHE_ADDRESS_BIT_WIDTH = 5,
  parameter int ROW_WIDTH               = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [BIT_WIDTH-1:0]               pixel_i,
  input  logic                               pixel_valid_i,
  output logic                               pixel_ready_o,
  input  logic [2:0]                         kernel_rows_i,
  input  logic                               start_i,
  input  logic                               flush_i,
  output logic                               wr_en_o,
  output logic [CACHE_CHANNEL_BIT_WIDTH-1:0] channel_wr_sel_o,
  output logic [CACHE_ADDRESS_BIT_WIDTH-1:0] address_wr_o,
  output logic [BIT_WIDTH-1:0]               cache_data_o,
  output logic                               rd_en_o,
  output logic [CACHE_CHANNELS-1:0]          channel_rd_sel_o,
  output logic [CACHE_ADDRESS_BIT_WIDTH-1:0] address_rd_o,
  output logic                               fetch_valid_o,
  output logic [CACHE_CHANNEL_BIT_WIDTH-1:0] window_base_o,
  output logic [2:0]                         rows_filled_o,
  output logic                               done_o
);

  localparam int CW = CACHE_CHANNEL_BIT_WIDTH;
  localparam int AW = CACHE_ADDRESS_BIT_WIDTH;
  localparam logic [AW-1:0] LAST_COL = AW'(ROW_WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CACHE_CHANNELS - 1);
  localparam logic [2:0]    FULL     = 3'(CACHE_CHANNELS);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic                    pending;
  logic [2:0]              k_lat;
  logic [CW-1:0]           wr_ch, oldest_ch, base_lat;
  logic [AW-1:0]           wr_col, rd_addr;
  logic [2:0]              rows_filled;
  logic [CACHE_CHANNELS-1:0] mask_lat;
  logic                    hs_p0, row_done_p0, release_row, sweep_go;

  logic                    wr_vld_p1;
  logic [CW-1:0]           wr_ch_p1;
  logic [AW-1:0]           wr_addr_p1;
  logic [BIT_WIDTH-1:0]    wr_data_p1;
  logic                    fetch_vld_p1;

  // Channel index increment modulo the channel count.
  function automatic logic [CW-1:0] ch_inc(input logic [CW-1:0] c);
    return (c == LAST_CH) ? '0 : c + CW'(1);
  endfunction

  // Mask of k consecutive channels starting at base (wrapping); channel 0 is the MSB.
  function automatic logic [CACHE_CHANNELS-1:0] window_mask(input logic [CW-1:0] base,
                                                            input logic [2:0]    k);
    logic [CACHE_CHANNELS-1:0] m;
    logic [CW-1:0]             c;
    m = '0;
    c = base;
    for (int i = 0; i < CACHE_CHANNELS; i++) begin
      if (i < int'(k))
        m = m | (CACHE_CHANNELS'(1) << (CACHE_CHANNELS - 1 - int'(c)));
      c = ch_inc(c);
    end
    return m;
  endfunction

  // ---- stage p0: stream handshake and row bookkeeping ----
  assign pixel_ready_o = (rows_filled < FULL) && !flush_i;
  assign hs_p0         = pixel_valid_i && pixel_ready_o;
  assign row_done_p0   = hs_p0 && (wr_col == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rd_en_o     = 1'b0;
    done_o      = 1'b0;
    sweep_go    = 1'b0;
    release_row = 1'b0;
    case (state)
      IDLE: begin
        if (pending && (rows_filled >= k_lat)) begin
          sweep_go  = 1'b1;
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        rd_en_o = 1'b1;
        if (rd_addr == LAST_COL) state_nxt = DRAIN;
      end
      DRAIN: begin
        done_o      = 1'b1;
        release_row = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  assign address_rd_o     = (state == SWEEP) ? rd_addr  : '0;
  assign channel_rd_sel_o = (state == SWEEP) ? mask_lat : '0;
  assign window_base_o    = base_lat;
  assign rows_filled_o    = rows_filled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      k_lat        <= '0;
      wr_ch        <= '0;
      wr_col       <= '0;
      oldest_ch    <= '0;
      rows_filled  <= '0;
      rd_addr      <= '0;
      base_lat     <= '0;
      mask_lat     <= '0;
      wr_vld_p1    <= 1'b0;
      fetch_vld_p1 <= 1'b0;
    end else if (flush_i) begin
      pending      <= 1'b0;
      wr_ch        <= '0;
      wr_col       <= '0;
      oldest_ch    <= '0;
      rows_filled  <= '0;
      rd_addr      <= '0;
      wr_vld_p1    <= 1'b0;
      fetch_vld_p1 <= 1'b0;
    end else begin
      // A new request always wins over the clear that accompanies sweep entry.
      if (start_i) begin
        pending <= 1'b1;
        k_lat   <= (kernel_rows_i == 3'd0) ? 3'd1 : kernel_rows_i;
      end else if (sweep_go) begin
        pending <= 1'b0;
      end

      if (sweep_go) begin
        base_lat <= oldest_ch;
        mask_lat <= window_mask(oldest_ch, k_lat);
        rd_addr  <= '0;
      end else if (state == SWEEP) begin
        rd_addr  <= rd_addr + AW'(1);
      end

      if (hs_p0) begin
        if (row_done_p0) begin
          wr_col <= '0;
          wr_ch  <= ch_inc(wr_ch);
        end else begin
          wr_col <= wr_col + AW'(1);
        end
      end

      if (release_row) oldest_ch <= ch_inc(oldest_ch);

      // Completion and release in the same cycle cancel out.
      if (row_done_p0 && !release_row)      rows_filled <= rows_filled + 3'd1;
      else if (!row_done_p0 && release_row) rows_filled <= rows_filled - 3'd1;

      wr_vld_p1    <= hs_p0;
      fetch_vld_p1 <= rd_en_o;
    end
  end

  // ---- stage p1: registered cache write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ch_p1   <= '0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else if (hs_p0) begin
      wr_ch_p1   <= wr_ch;
      wr_addr_p1 <= wr_col;
      wr_data_p1 <= pixel_i;
    end
  end

  assign wr_en_o          = wr_vld_p1;
  assign channel_wr_sel_o = wr_ch_p1;
  assign address_wr_o     = wr_addr_p1;
  assign cache_data_o     = wr_data_p1;
  assign fetch_valid_o    = fetch_vld_p1;

endmodule

// File: tb/tb_cache_rd_wr_ctrl.sv
module tb_cache_rd_wr_ctrl;
  localparam int BW = 8;
  localparam int RW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pixel_i = '0;
  logic       pixel_valid_i = 1'b0;
  logic       pixel_ready_o;
  logic [2:0] kernel_rows_i = '0;
  logic       start_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       wr_en_o;
  logic [2:0] channel_wr_sel_o;
  logic [4:0] address_wr_o;
  logic [7:0] cache_data_o;
  logic       rd_en_o;
  logic [6:0] channel_rd_sel_o;
  logic [4:0] address_rd_o;
  logic       fetch_valid_o;
  logic [2:0] window_base_o;
  logic [2:0] rows_filled_o;
  logic       done_o;

  always #5 clk = ~clk;

  cache_rd_wr_ctrl #(
    .BIT_WIDTH(BW), .CACHE_CHANNELS(7), .CACHE_CHANNEL_BIT_WIDTH(3),
    .CACHE_ADDRESS_BIT_WIDTH(5), .ROW_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o), .kernel_rows_i(kernel_rows_i), .start_i(start_i),
    .flush_i(flush_i), .wr_en_o(wr_en_o), .channel_wr_sel_o(channel_wr_sel_o),
    .address_wr_o(address_wr_o), .cache_data_o(cache_data_o), .rd_en_o(rd_en_o),
    .channel_rd_sel_o(channel_rd_sel_o), .address_rd_o(address_rd_o),
    .fetch_valid_o(fetch_valid_o), .window_base_o(window_base_o),
    .rows_filled_o(rows_filled_o), .done_o(done_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channels base .. base+k-1 (mod 7) selected; channel c lives in bit 6-c.
  function automatic logic [6:0] exp_mask(input int base, input int k);
    logic [6:0] m;
    m = '0;
    for (int c = 0; c < 7; c++)
      if (((c - base + 7) % 7) < k) m = m | (7'd1 << (6 - c));
    return m;
  endfunction

  // Reference model: row occupancy counters plus a sweep position
  // (-1 idle, 0..RW-1 reading that address, RW the release cycle).
  int         m_rows, m_wr_ch, m_wr_col, m_oldest, m_k, m_pos, m_base, m_ksw;
  bit         m_pend, e_wr_en, e_fetch;
  int         e_wr_ch, e_wr_addr;
  logic [7:0] e_data;

  always @(posedge clk or negedge rst_n) begin
    bit hs, rd_now, row_done, rel, go;
    if (!rst_n) begin
      m_rows = 0; m_wr_ch = 0; m_wr_col = 0; m_oldest = 0; m_k = 0;
      m_pos = -1; m_base = 0; m_ksw = 0; m_pend = 0;
      e_wr_en = 0; e_fetch = 0; e_wr_ch = 0; e_wr_addr = 0; e_data = '0;
    end else begin
      hs = pixel_valid_i && (m_rows < 7) && !flush_i;
      e_wr_en = hs;
      if (hs) begin
        e_wr_ch = m_wr_ch; e_wr_addr = m_wr_col; e_data = pixel_i;
      end
      if (flush_i) begin
        m_rows = 0; m_wr_ch = 0; m_wr_col = 0; m_oldest = 0;
        m_pend = 0; m_pos = -1; e_fetch = 0;
      end else begin
        rd_now   = (m_pos >= 0) && (m_pos < RW);
        e_fetch  = rd_now;
        rel      = (m_pos == RW);
        go       = (m_pos < 0) && m_pend && (m_rows >= m_k);
        row_done = hs && (m_wr_col == RW - 1);
        if (go) begin
          m_base = m_oldest; m_ksw = m_k; m_pos = 0;
        end else if (rd_now) m_pos++;
        else if (rel) m_pos = -1;
        if (start_i) begin
          m_pend = 1;
          m_k = (kernel_rows_i == 0) ? 1 : int'(kernel_rows_i);
        end else if (go) m_pend = 0;
        if (hs) begin
          if (row_done) begin m_wr_col = 0; m_wr_ch = (m_wr_ch + 1) % 7; end
          else m_wr_col++;
        end
        if (rel) m_oldest = (m_oldest + 1) % 7;
        m_rows = m_rows + int'(row_done) - int'(rel);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit rd;
    if (chk_en && rst_n) begin
      rd = (m_pos >= 0) && (m_pos < RW);
      chk("rd_en", rd_en_o, rd);
      chk("address_rd", address_rd_o, rd ? m_pos : 0);
      chk("rd_mask", channel_rd_sel_o, rd ? exp_mask(m_base, m_ksw) : 7'd0);
      chk("done", done_o, m_pos == RW);
      chk("fetch_valid", fetch_valid_o, e_fetch);
      chk("rows_filled", rows_filled_o, m_rows);
      chk("pixel_ready", pixel_ready_o, (m_rows < 7) && !flush_i);
      chk("wr_en", wr_en_o, e_wr_en);
      if (e_wr_en) begin
        chk("wr_channel", channel_wr_sel_o, e_wr_ch);
        chk("wr_address", address_wr_o, e_wr_addr);
        chk("wr_data", cache_data_o, e_data);
      end
      if (rd) chk("window_base", window_base_o, m_base);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_pixels(input int n);
    int sent, guard;
    sent = 0; guard = 0;
    while (sent < n && guard < 5000) begin
      pixel_valid_i = 1'b1;
      pixel_i = 8'($urandom);
      #1;
      if (pixel_ready_o) sent++;
      tick();
      guard++;
    end
    pixel_valid_i = 1'b0;
    if (sent < n) chk("send_pixels_timeout", sent, n);
  endtask

  task automatic start_sweep(input int k);
    kernel_rows_i = 3'(k);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic sweep_window(input int ncyc, output int fetches, output int dones,
                              output logic [6:0] mask, output logic [2:0] base);
    bit got;
    got = 0; fetches = 0; dones = 0; mask = '0; base = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (fetch_valid_o) fetches++;
      if (done_o) dones++;
      if (rd_en_o && !got) begin
        got = 1; mask = channel_rd_sel_o; base = window_base_o;
      end
      tick();
    end
  endtask

  task automatic wait_rd_addr(input int a, output bit found);
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (rd_en_o && address_rd_o == 5'(a)) found = 1;
      else tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int         f, d, rdc, r;
    logic [6:0] msk;
    logic [2:0] b;
    bit         found;

    repeat (3) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    // Reset state
    chk("reset_rows", rows_filled_o, 0);
    chk("reset_ready", pixel_ready_o, 1);
    chk("reset_rd_en", rd_en_o, 0);
    chk("reset_mask", channel_rd_sel_o, 0);
    chk("reset_fetch", fetch_valid_o, 0);
    chk("reset_wr_en", wr_en_o, 0);

    // Three rows, k=3 sweep from channel 0
    send_pixels(96);
    chk("three_rows", rows_filled_o, 3);
    start_sweep(3);
    sweep_window(45, f, d, msk, b);
    chk("k3_mask", msk, 7'b1110000);
    chk("k3_fetches", f, 32);
    chk("k3_done", d, 1);
    chk("k3_rows_after", rows_filled_o, 2);

    // Next window starts at channel 1
    start_sweep(2);
    sweep_window(45, f, d, msk, b);
    chk("k2_base", b, 1);
    chk("k2_mask", msk, 7'b0110000);
    chk("k2_rows_after", rows_filled_o, 1);

    // Request with too few rows waits until the third row completes
    start_sweep(3);
    rdc = 0;
    for (int i = 0; i < 5; i++) begin
      rdc += int'(rd_en_o);
      tick();
    end
    chk("no_sweep_rows1", rdc, 0);
    send_pixels(64);
    chk("rows_reach3", rows_filled_o, 3);
    chk("still_idle", rd_en_o, 0);
    tick();
    chk("sweep_next_cycle", rd_en_o, 1);
    sweep_window(45, f, d, msk, b);
    chk("late_mask", msk, 7'b0011100);
    chk("late_base", b, 2);

    // Flush in the middle of a sweep
    start_sweep(2);
    wait_rd_addr(10, found);
    chk("reach_addr10", found, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_rd_en", rd_en_o, 0);
    chk("flush_rows", rows_filled_o, 0);
    chk("flush_fetch", fetch_valid_o, 0);
    sweep_window(40, f, d, msk, b);
    chk("flush_no_done", d, 0);
    pixel_valid_i = 1'b1; pixel_i = 8'hA5;
    tick();
    pixel_valid_i = 1'b0;
    chk("flush_wr_en", wr_en_o, 1);
    chk("flush_wr_ch", channel_wr_sel_o, 0);
    chk("flush_wr_addr", address_wr_o, 0);
    chk("flush_wr_data", cache_data_o, 8'hA5);

    // Fill all seven channels, then one full-height sweep
    send_pixels(223);
    chk("full_rows", rows_filled_o, 7);
    chk("full_ready", pixel_ready_o, 0);
    start_sweep(7);
    sweep_window(45, f, d, msk, b);
    chk("k7_mask", msk, 7'h7F);
    chk("k7_rows_after", rows_filled_o, 6);
    chk("k7_ready_after", pixel_ready_o, 1);
    pixel_valid_i = 1'b1; pixel_i = 8'h11;
    tick();
    pixel_valid_i = 1'b0;
    chk("wrap_wr_ch", channel_wr_sel_o, 0);
    chk("wrap_wr_addr", address_wr_o, 0);

    // Last pixel of a row accepted during the release cycle
    send_pixels(30);
    start_sweep(1);
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (done_o) found = 1;
      else tick();
    end
    chk("reach_drain", found, 1);
    r = int'(rows_filled_o);
    pixel_valid_i = 1'b1; pixel_i = 8'h3C;
    tick();
    pixel_valid_i = 1'b0;
    chk("drain_rows_unchanged", rows_filled_o, r);
    chk("drain_rows_value", rows_filled_o, 6);
    chk("drain_wr_addr", address_wr_o, 31);

    // Wrapping window: eight rows written, five released
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    send_pixels(96);
    for (int it = 0; it < 5; it++) begin
      start_sweep(1);
      sweep_window(45, f, d, msk, b);
      send_pixels(32);
    end
    start_sweep(3);
    sweep_window(45, f, d, msk, b);
    chk("wrap_base", b, 5);
    chk("wrap_mask", msk, 7'b1000011);

    // Asynchronous reset mid-sweep
    start_sweep(2);
    wait_rd_addr(5, found);
    chk("reach_addr5", found, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en", rd_en_o, 0);
    chk("arst_mask", channel_rd_sel_o, 0);
    chk("arst_addr", address_rd_o, 0);
    chk("arst_rows", rows_filled_o, 0);
    chk("arst_fetch", fetch_valid_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_wr", {wr_en_o, channel_wr_sel_o, address_wr_o, cache_data_o}, 0);
    chk("arst_base", window_base_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      pixel_valid_i = ($urandom_range(0, 3) != 0);
      pixel_i       = 8'($urandom);
      start_i       = ($urandom_range(0, 19) == 0);
      kernel_rows_i = 3'($urandom_range(0, 7));
      flush_i       = ($urandom_range(0, 299) == 0);
      tick();
    end
    pixel_valid_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    repeat (50) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
